// File: rtl/vmem_spike_monitor.sv
// vmem_spike_monitor: threshold-crossing spike detector with refractory
// lockout, hysteresis re-arm and a saturating windowed spike-rate counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         cycle enable; en=0 freezes all state
//   v_mem      membrane voltage (unsigned, WIDTH bits)
//   thresh     firing threshold (unsigned, WIDTH bits)
//   spike_o    one-cycle spike pulse, one cycle after detection
//   rate_o     spikes in last completed window, saturating at 255
//   rate_valid one-cycle pulse when rate_o updates
//   refrac_o   high while refractory or waiting for re-arm
module vmem_spike_monitor #(
  parameter int WIDTH       = 8,
  parameter int WINDOW_LOG2 = 10,
  parameter int REFRAC_CYC  = 4,
  parameter int HYST        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] v_mem,
  input  logic [WIDTH-1:0] thresh,
  output logic             spike_o,
  output logic [7:0]       rate_o,
  output logic             rate_valid,
  output logic             refrac_o
);

  localparam int RW = $clog2(REFRAC_CYC + 1);
  localparam logic [RW-1:0] RC_W = RW'(REFRAC_CYC);
  localparam logic [RW-1:0] ONE_W = RW'(1);
  localparam logic [WIDTH:0] HYST_W = (WIDTH+1)'(HYST);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    REFRAC   = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                 r_state;
  logic [RW-1:0]          r_rcnt;
  logic [WINDOW_LOG2-1:0] r_win;
  logic [7:0]             r_count;

  state_t                 w_nstate;
  logic [RW-1:0]          w_nrcnt;
  logic [WIDTH:0]         w_thr;
  logic [WIDTH:0]         w_rearm;
  logic                   w_low;
  logic                   w_det;
  logic                   w_wrap;
  logic [8:0]             w_sum;
  logic [7:0]             w_sat;

  // Re-arm level floors at 0; with thresh <= HYST the block
  // never re-arms after its first spike.
  assign w_thr   = {1'b0, thresh};
  assign w_rearm = (w_thr > HYST_W) ? (w_thr - HYST_W) : '0;
  assign w_low   = {1'b0, v_mem} < w_rearm;

  assign w_det  = (r_state == ARMED) && en && (v_mem >= thresh);
  assign w_wrap = &r_win;

  // Detect on the wrap cycle still counts toward the closing window.
  assign w_sum = {1'b0, r_count} + 9'(w_det);
  assign w_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

  always_comb begin
    w_nstate = r_state;
    w_nrcnt  = r_rcnt;
    if (en) begin
      unique case (1'b1)
        (r_state == ARMED): begin
          if (w_det) begin
            w_nstate = REFRAC;
            w_nrcnt  = RC_W;
          end
        end
        (r_state == REFRAC): begin
          if (r_rcnt == ONE_W) begin
            w_nstate = WAIT_LOW;
            w_nrcnt  = '0;
          end else begin
            w_nrcnt = r_rcnt - ONE_W;
          end
        end
        (r_state == WAIT_LOW): begin
          if (w_low) w_nstate = ARMED;
        end
        default: begin
          w_nstate = ARMED;
          w_nrcnt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARMED;
      r_rcnt     <= '0;
      r_win      <= '0;
      r_count    <= '0;
      spike_o    <= 1'b0;
      rate_o     <= '0;
      rate_valid <= 1'b0;
      refrac_o   <= 1'b0;
    end else begin
      spike_o    <= w_det;
      rate_valid <= en & w_wrap;
      refrac_o   <= (w_nstate != ARMED);
      r_state    <= w_nstate;
      r_rcnt     <= w_nrcnt;
      if (en) begin
        r_win <= r_win + WINDOW_LOG2'(1);
        if (w_wrap) begin
          rate_o  <= w_sat;
          r_count <= '0;
        end else begin
          r_count <= w_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_vmem_spike_monitor.sv
// tb_vmem_spike_monitor: two parameterisations of the spike monitor
// compared cycle by cycle against an event-level reference model.
module tb_vmem_spike_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_en, b_en;
  logic [7:0] a_v, a_th, b_v, b_th;
  logic       a_spk, b_spk, a_rv, b_rv, a_rf, b_rf;
  logic [7:0] a_rate, b_rate;

  vmem_spike_monitor #(
    .WIDTH(8), .WINDOW_LOG2(4), .REFRAC_CYC(3), .HYST(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en),
    .v_mem(a_v), .thresh(a_th),
    .spike_o(a_spk), .rate_o(a_rate),
    .rate_valid(a_rv), .refrac_o(a_rf)
  );

  vmem_spike_monitor #(
    .WIDTH(8), .WINDOW_LOG2(10), .REFRAC_CYC(1), .HYST(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en),
    .v_mem(b_v), .thresh(b_th),
    .spike_o(b_spk), .rate_o(b_rate),
    .rate_valid(b_rv), .refrac_o(b_rf)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: per instance, an armed flag, the enabled-cycle
  // index of the last spike, and a plain spike tally per window.
  int p_rc[2]  = '{3, 1};
  int p_hy[2]  = '{8, 0};
  int p_win[2] = '{16, 1024};
  int m_armed[2], m_last[2], m_n[2], m_tally[2];
  int e_spk[2], e_rate[2], e_rv[2], e_rf[2];

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_armed[k] = 1;
      m_last[k]  = -100000;
      m_n[k]     = 0;
      m_tally[k] = 0;
      e_spk[k]   = 0;
      e_rate[k]  = 0;
      e_rv[k]    = 0;
      e_rf[k]    = 0;
    end
  endfunction

  function automatic void m_step(int k, bit en, int v, int th);
    int rearm;
    int det;
    e_spk[k] = 0;
    e_rv[k]  = 0;
    if (!en) return;
    rearm = (th > p_hy[k]) ? th - p_hy[k] : 0;
    det = 0;
    if (m_armed[k] != 0) begin
      if (v >= th) begin
        det = 1;
        m_armed[k] = 0;
        m_last[k] = m_n[k];
      end
    end else if ((m_n[k] - m_last[k] > p_rc[k]) && (v < rearm)) begin
      m_armed[k] = 1;
    end
    e_spk[k] = det;
    e_rf[k]  = (m_armed[k] == 0) ? 1 : 0;
    m_tally[k] += det;
    if (m_n[k] % p_win[k] == p_win[k] - 1) begin
      e_rate[k]  = (m_tally[k] > 255) ? 255 : m_tally[k];
      e_rv[k]    = 1;
      m_tally[k] = 0;
    end
    m_n[k]++;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("a_spike", {31'd0, a_spk}, e_spk[0]);
    chk("a_rate",  {24'd0, a_rate}, e_rate[0]);
    chk("a_rvalid", {31'd0, a_rv}, e_rv[0]);
    chk("a_refrac", {31'd0, a_rf}, e_rf[0]);
    chk("b_spike", {31'd0, b_spk}, e_spk[1]);
    chk("b_rate",  {24'd0, b_rate}, e_rate[1]);
    chk("b_rvalid", {31'd0, b_rv}, e_rv[1]);
    chk("b_refrac", {31'd0, b_rf}, e_rf[1]);
  endtask

  int a_pulses;

  task automatic step();
    m_step(0, a_en, int'(a_v), int'(a_th));
    m_step(1, b_en, int'(b_v), int'(b_th));
    @(posedge clk);
    #1;
    chk_all();
    if (a_spk === 1'b1) a_pulses++;
  endtask

  task automatic run_a(int v, int n);
    for (int i = 0; i < n; i++) begin
      a_v = 8'(v);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b0; a_v = '0; a_th = 8'd100;
    b_en = 1'b0; b_v = '0; b_th = 8'd1;
    a_pulses = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;

    // Single crossing
    a_en = 1'b1;
    run_a(50, 3);
    a_pulses = 0;
    run_a(120, 1);
    chk("single_first", {31'd0, a_spk}, 1);
    run_a(120, 9);
    chk("single_refrac_held", {31'd0, a_rf}, 1);
    run_a(50, 3);
    chk("single_count", a_pulses, 1);
    chk("single_rearmed", {31'd0, a_rf}, 0);

    // Hysteresis: 95 does not re-arm, 91 does
    run_a(120, 6);
    run_a(95, 2);
    a_pulses = 0;
    run_a(120, 3);
    chk("hyst_95_suppressed", a_pulses, 0);
    run_a(91, 2);
    run_a(120, 1);
    chk("hyst_91_fires", {31'd0, a_spk}, 1);
    run_a(50, 4);

    // Refractory floor with a toggling input
    for (int i = 0; i < 48; i++) run_a((i % 2 == 0) ? 120 : 50, 1);

    // Window boundary: detect on the last cycle of a window
    run_a(50, 8);
    while (m_n[0] % 16 != 15) run_a(50, 1);
    run_a(120, 1);
    chk("wb_rvalid", {31'd0, a_rv}, 1);
    chk("wb_rate", {24'd0, a_rate}, 1);
    run_a(50, 16);
    chk("wb_next_rvalid", {31'd0, a_rv}, 1);
    chk("wb_next_rate", {24'd0, a_rate}, 0);

    // Enable freeze mid-refractory
    run_a(120, 2);
    a_pulses = 0;
    a_en = 1'b0;
    for (int i = 0; i < 20; i++) run_a(int'($urandom_range(0, 255)), 1);
    chk("freeze_pulses", a_pulses, 0);
    chk("freeze_refrac", {31'd0, a_rf}, 1);
    a_en = 1'b1;
    run_a(50, 6);

    // Randomized traffic with occasional threshold changes
    for (int i = 0; i < 400; i++) begin
      a_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) a_th = 8'($urandom_range(60, 140));
      run_a(int'($urandom_range(50, 150)), 1);
    end
    a_en = 1'b1;
    a_th = 8'd100;
    run_a(120, 5);

    // Asynchronous reset mid-window
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_all();
    @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;
    run_a(120, 1);
    chk("post_reset_spike", {31'd0, a_spk}, 1);
    run_a(50, 6);

    // Saturation on the wide-window instance
    a_en = 1'b0;
    b_en = 1'b1;
    b_th = 8'd1;
    while (m_n[1] % 1024 != 0) begin
      b_v = 8'd0;
      step();
    end
    for (int i = 0; i < 2048; i++) begin
      b_v = (i % 2 == 0) ? 8'd200 : 8'd0;
      step();
    end
    chk("sat_rvalid", {31'd0, b_rv}, 1);
    chk("sat_rate", {24'd0, b_rate}, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
